// File: rtl/map_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : map_access_arbiter
//  Description : Owns the maze map RAM. During LOAD only the map loader may
//                write; once DEPTH writes have been acked the block moves to
//                RUN, where the move-checker and display scanner share the
//                single read port with round-robin arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module map_access_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  // map loader write port
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ack_o,
  // phase control
  input  logic              reload_i,
  output logic              map_ready_o,
  // move-checker read port
  input  logic              mv_req_i,
  input  logic [ADDR_W-1:0] mv_addr_i,
  output logic              mv_ack_o,
  output logic [DATA_W-1:0] mv_rdata_o,
  // display scanner read port
  input  logic              ds_req_i,
  input  logic [ADDR_W-1:0] ds_addr_i,
  output logic              ds_ack_o,
  output logic [DATA_W-1:0] ds_rdata_o
);

  // Counter must be able to hold the value DEPTH itself.
  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    RR_MV = 1'b0,
    RR_DS = 1'b1
  } rr_e;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_e              state_q;
  rr_e                 rr_last_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic [CNT_W-1:0]    wr_cnt_d;
  logic                map_ready_q;
  logic                ld_ack_q;
  logic                mv_ack_q;
  logic                ds_ack_q;
  logic [DATA_W-1:0]   mv_rdata_q;
  logic [DATA_W-1:0]   ds_rdata_q;

  // Map storage; deliberately not reset so a reset never wipes a loaded map.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake decode and arbitration
  // --------------------------------------------------------------------------
  logic                w_in_load;
  logic                w_in_run;
  logic                w_ld_fire;
  logic                w_ld_in_rng;
  logic                w_mv_in_rng;
  logic                w_ds_in_rng;
  logic                w_mv_elig;
  logic                w_ds_elig;
  logic                w_mv_gnt;
  logic                w_ds_gnt;
  logic [DATA_W-1:0]   w_mv_rd;
  logic [DATA_W-1:0]   w_ds_rd;

  assign w_in_load   = (state_q == ST_LOAD);
  assign w_in_run    = (state_q == ST_RUN);

  // A request still held during its own ack cycle must not be served twice.
  assign w_ld_fire   = w_in_load && ld_req_i && !ld_ack_q;

  assign w_ld_in_rng = ({1'b0, ld_addr_i} < ADDR_LIMIT);
  assign w_mv_in_rng = ({1'b0, mv_addr_i} < ADDR_LIMIT);
  assign w_ds_in_rng = ({1'b0, ds_addr_i} < ADDR_LIMIT);

  assign w_mv_elig   = w_in_run && mv_req_i && !mv_ack_q;
  assign w_ds_elig   = w_in_run && ds_req_i && !ds_ack_q;

  // On a tie the port that was not served last wins.
  assign w_mv_gnt    = w_mv_elig && (!w_ds_elig || (rr_last_q == RR_DS));
  assign w_ds_gnt    = w_ds_elig && (!w_mv_elig || (rr_last_q == RR_MV));

  // Out-of-range reads return zero rather than an undefined cell.
  assign w_mv_rd     = w_mv_in_rng ? mem_q[mv_addr_i] : '0;
  assign w_ds_rd     = w_ds_in_rng ? mem_q[ds_addr_i] : '0;

  // Write counter next value: reload restarts counting even if a write lands.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (reload_i) begin
      wr_cnt_d = '0;
    end else if (w_ld_fire && (wr_cnt_q != CNT_FULL)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // Phase FSM, arbitration history, acks and read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      rr_last_q   <= RR_DS;
      wr_cnt_q    <= '0;
      map_ready_q <= 1'b0;
      ld_ack_q    <= 1'b0;
      mv_ack_q    <= 1'b0;
      ds_ack_q    <= 1'b0;
      mv_rdata_q  <= '0;
      ds_rdata_q  <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      ld_ack_q <= w_ld_fire;
      mv_ack_q <= w_mv_gnt;
      ds_ack_q <= w_ds_gnt;

      if (w_mv_gnt) begin
        mv_rdata_q <= w_mv_rd;
        rr_last_q  <= RR_MV;
      end
      if (w_ds_gnt) begin
        ds_rdata_q <= w_ds_rd;
        rr_last_q  <= RR_DS;
      end

      case (state_q)
        ST_LOAD: begin
          // The count reached DEPTH on the previous edge; enter RUN now.
          if (!reload_i && (wr_cnt_q == CNT_FULL)) begin
            state_q     <= ST_RUN;
            map_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (reload_i) begin
            state_q     <= ST_LOAD;
            map_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_LOAD;
          map_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port, used only by the loader while in LOAD.
  always_ff @(posedge clk) begin
    if (w_ld_fire && w_ld_in_rng) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  assign ld_ack_o    = ld_ack_q;
  assign map_ready_o = map_ready_q;
  assign mv_ack_o    = mv_ack_q;
  assign mv_rdata_o  = mv_rdata_q;
  assign ds_ack_o    = ds_ack_q;
  assign ds_rdata_o  = ds_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_map_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_map_access_arbiter
//  Description : Directed self-checking bench for map_access_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_map_access_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_req = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [1:0] ld_data = '0;
  logic       ld_ack;
  logic       reload = 1'b0;
  logic       map_ready;
  logic       mv_req = 1'b0;
  logic [5:0] mv_addr = '0;
  logic       mv_ack;
  logic [1:0] mv_rdata;
  logic       ds_req = 1'b0;
  logic [5:0] ds_addr = '0;
  logic       ds_ack;
  logic [1:0] ds_rdata;

  int total = 0;
  int bad   = 0;

  map_access_arbiter #(.ADDR_W(6), .DATA_W(2), .DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_req_i   (ld_req),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .ld_ack_o   (ld_ack),
    .reload_i   (reload),
    .map_ready_o(map_ready),
    .mv_req_i   (mv_req),
    .mv_addr_i  (mv_addr),
    .mv_ack_o   (mv_ack),
    .mv_rdata_o (mv_rdata),
    .ds_req_i   (ds_req),
    .ds_addr_i  (ds_addr),
    .ds_ack_o   (ds_ack),
    .ds_rdata_o (ds_rdata)
  );

  always #5 clk = ~clk;

  // Everything is driven and sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Map pattern used by the first load: cell = addr[0] ^ addr[3].
  function automatic logic [1:0] pat(input int a);
    return {1'b0, a[0] ^ a[3]};
  endfunction

  // Loader stimulus: n consecutive writes starting at first; reports ack and
  // stray read-ack counts for the caller to judge.
  task automatic load_map(input int first, input int n, input bit ones,
                          output int acks, output int stray);
    bit got;
    acks  = 0;
    stray = 0;
    for (int a = first; a < first + n; a++) begin
      ld_req  = 1'b1;
      ld_addr = a[5:0];
      ld_data = ones ? 2'b11 : pat(a);
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        if (mv_ack || ds_ack) stray++;
        if (ld_ack) got = 1'b1;
      end
      if (got) acks++;
    end
    ld_req = 1'b0;
  endtask

  // Single read on one port; ok=0 if no ack arrives within the budget.
  task automatic do_read(input bit use_ds, input int addr,
                         output logic [1:0] data, output bit ok);
    ok   = 1'b0;
    data = 'x;
    if (use_ds) begin ds_req = 1'b1; ds_addr = addr[5:0]; end
    else        begin mv_req = 1'b1; mv_addr = addr[5:0]; end
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (use_ds && ds_ack)  begin ok = 1'b1; data = ds_rdata; end
      if (!use_ds && mv_ack) begin ok = 1'b1; data = mv_rdata; end
    end
    ds_req = 1'b0;
    mv_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL reset_map_ready got=%b want=0", map_ready); end
    total++; if (ld_ack !== 1'b0)    begin bad++; $display("FAIL reset_ld_ack got=%b want=0", ld_ack); end
    total++; if (mv_ack !== 1'b0)    begin bad++; $display("FAIL reset_mv_ack got=%b want=0", mv_ack); end
    total++; if (ds_ack !== 1'b0)    begin bad++; $display("FAIL reset_ds_ack got=%b want=0", ds_ack); end
    total++; if (mv_rdata !== 2'b00) begin bad++; $display("FAIL reset_mv_rdata got=%0d want=0", mv_rdata); end
    total++; if (ds_rdata !== 2'b00) begin bad++; $display("FAIL reset_ds_rdata got=%0d want=0", ds_rdata); end
    rst = 1'b0;
  endtask

  // Full pattern load with a move-check read pending throughout.
  task automatic test_load_and_stall();
    int acks, stray;
    mv_req  = 1'b1;
    mv_addr = 6'd12;
    load_map(0, 64, 1'b0, acks, stray);
    total++; if (acks !== 64)  begin bad++; $display("FAIL load_acks got=%0d want=64", acks); end
    total++; if (stray !== 0)  begin bad++; $display("FAIL load_stall_acks got=%0d want=0", stray); end
    total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL ready_at_last_ack got=%b want=0", map_ready); end
    tick();
    total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL ready_after_last_ack got=%b want=1", map_ready); end
    total++; if (mv_ack !== 1'b0)    begin bad++; $display("FAIL mv_ack_first_run got=%b want=0", mv_ack); end
    tick();
    total++; if (mv_ack !== 1'b1)    begin bad++; $display("FAIL mv_ack_second_run got=%b want=1", mv_ack); end
    total++; if (mv_rdata !== 2'd1)  begin bad++; $display("FAIL mv_rdata_12 got=%0d want=1", mv_rdata); end
    mv_req = 1'b0;
    tick();
  endtask

  // Both readers held; last grant was MV, so DS wins the first tie.
  task automatic test_back_to_back();
    int  mv_i = 0, ds_i = 0, order_err = 0, both = 0;
    bit  expect_ds = 1'b1;
    mv_addr = 6'd0;
    ds_addr = 6'd0;
    mv_req  = 1'b1;
    ds_req  = 1'b1;
    for (int c = 0; c < 100 && (mv_i < 16 || ds_i < 16); c++) begin
      tick();
      if (mv_ack && ds_ack) both++;
      if (ds_ack) begin
        if (!expect_ds) order_err++;
        expect_ds = 1'b0;
        total++;
        if (ds_rdata !== pat(ds_i)) begin
          bad++; $display("FAIL rr_ds_rdata addr=%0d got=%0d want=%0d", ds_i, ds_rdata, pat(ds_i));
        end
        ds_i++;
        if (ds_i == 16) ds_req = 1'b0; else ds_addr = ds_i[5:0];
      end
      if (mv_ack) begin
        if (expect_ds) order_err++;
        expect_ds = 1'b1;
        total++;
        if (mv_rdata !== pat(mv_i)) begin
          bad++; $display("FAIL rr_mv_rdata addr=%0d got=%0d want=%0d", mv_i, mv_rdata, pat(mv_i));
        end
        mv_i++;
        if (mv_i == 16) mv_req = 1'b0; else mv_addr = mv_i[5:0];
      end
    end
    mv_req = 1'b0;
    ds_req = 1'b0;
    total++; if (mv_i !== 16)     begin bad++; $display("FAIL rr_mv_count got=%0d want=16", mv_i); end
    total++; if (ds_i !== 16)     begin bad++; $display("FAIL rr_ds_count got=%0d want=16", ds_i); end
    total++; if (order_err !== 0) begin bad++; $display("FAIL rr_alternation errors got=%0d want=0", order_err); end
    total++; if (both !== 0)      begin bad++; $display("FAIL rr_dual_ack cycles got=%0d want=0", both); end
    tick();
  endtask

  // Reload from RUN, reload map with all-ones, reads stall then see 2'b11.
  task automatic test_reload();
    int acks, stray;
    logic [1:0] d;
    bit ok;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL reload_ready got=%b want=0", map_ready); end
    mv_req  = 1'b1;
    mv_addr = 6'd7;
    load_map(0, 64, 1'b1, acks, stray);
    total++; if (acks !== 64) begin bad++; $display("FAIL reload_acks got=%0d want=64", acks); end
    total++; if (stray !== 0) begin bad++; $display("FAIL reload_stall_acks got=%0d want=0", stray); end
    tick();
    total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL reload_ready_back got=%b want=1", map_ready); end
    tick();
    total++; if (mv_ack !== 1'b1)   begin bad++; $display("FAIL reload_mv_ack got=%b want=1", mv_ack); end
    total++; if (mv_rdata !== 2'b11) begin bad++; $display("FAIL reload_mv_rdata got=%0d want=3", mv_rdata); end
    mv_req = 1'b0;
    tick();
    do_read(1'b1, 0, d, ok);
    total++; if (!ok || d !== 2'b11) begin bad++; $display("FAIL reload_ds_0 got=%0d ok=%0d want=3", d, ok); end
    do_read(1'b0, 33, d, ok);
    total++; if (!ok || d !== 2'b11) begin bad++; $display("FAIL reload_mv_33 got=%0d ok=%0d want=3", d, ok); end
    do_read(1'b1, 63, d, ok);
    total++; if (!ok || d !== 2'b11) begin bad++; $display("FAIL reload_ds_63 got=%0d ok=%0d want=3", d, ok); end
    tick();
  endtask

  // Reset after 10 writes throws away progress; 64 fresh writes are needed.
  task automatic test_reset_mid_load();
    int acks, stray;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_map(0, 10, 1'b1, acks, stray);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", map_ready); end
    total++; if (ld_ack !== 1'b0)    begin bad++; $display("FAIL midrst_ld_ack got=%b want=0", ld_ack); end
    load_map(0, 54, 1'b1, acks, stray);
    total++; if (acks !== 54) begin bad++; $display("FAIL midrst_acks54 got=%0d want=54", acks); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_after54 cyc=%0d got=%b want=0", c, map_ready); end
    end
    load_map(54, 10, 1'b1, acks, stray);
    total++; if (acks !== 10) begin bad++; $display("FAIL midrst_acks10 got=%0d want=10", acks); end
    total++; if (map_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_at_64 got=%b want=0", map_ready); end
    tick();
    total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after_64 got=%b want=1", map_ready); end
    tick();
  endtask

  // Loader requests in RUN must be ignored and leave the RAM untouched.
  task automatic test_ld_ignored_in_run();
    int n_ack = 0;
    logic [1:0] d;
    bit ok;
    ld_req  = 1'b1;
    ld_addr = 6'd5;
    ld_data = 2'b00;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ld_ack) n_ack++;
    end
    ld_req = 1'b0;
    total++; if (n_ack !== 0)        begin bad++; $display("FAIL run_ld_acks got=%0d want=0", n_ack); end
    total++; if (map_ready !== 1'b1) begin bad++; $display("FAIL run_ld_ready got=%b want=1", map_ready); end
    do_read(1'b0, 5, d, ok);
    total++; if (!ok || d !== 2'b11) begin bad++; $display("FAIL run_ld_addr5 got=%0d ok=%0d want=3", d, ok); end
  endtask

  initial begin
    test_reset();
    test_load_and_stall();
    test_back_to_back();
    test_reload();
    test_reset_mid_load();
    test_ld_ignored_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
